bound_search_512bit: RTL and testbench
======================================

BOUND_SEARCH_512BIT -- requirements
Module: bound_search_512bit

Interface
REQ-001 SHALL have parameter ROW_W, default 512, row width; only 512 is supported.
REQ-002 SHALL have parameter TIMEOUT, default 32, maximum cycles to wait for mask-generator done.
REQ-003 i_clk  input  1  clock; all state updates on rising edge.
REQ-004 i_rstn  input  1  reset, asynchronous, active-low.
REQ-005 i_start  input  1  request; sampled only in IDLE.
REQ-006 i_left_or_right  input  1  search side; 0=from MSB (bit 511) down, 1=from LSB (bit 0) up.
REQ-007 i_row  input  512  pixel row; sampled with i_start.
REQ-008 o_busy  output  1  high in every state except IDLE.
REQ-009 o_done  output  1  one-cycle completion pulse.
REQ-010 o_found  output  1  row contained at least one set bit.
REQ-011 o_err  output  1  mask-generator timeout occurred.
REQ-012 o_index  output  9  count of zero bits before first set bit on selected side.
REQ-013 o_mask  output  512  captured mask.
REQ-014 o_mg_trig  output  1  mask-generator trigger (level).
REQ-015 o_mg_left_or_right  output  1  side forwarded to mask generator.
REQ-016 o_mg_bound_index  output  9  bound index forwarded to mask generator.
REQ-017 i_mg_done  input  1  mask-generator done (level).
REQ-018 i_mg_mask  input  512  mask-generator result; valid only while i_mg_done=1.

Function
REQ-019 States SHALL be IDLE, SEARCH, REQ, REL, DONE.
REQ-020 IDLE and i_start=1 SHALL latch i_row, i_left_or_right, compute found=|i_row, clear step counter, and go to SEARCH.
REQ-021 SEARCH SHALL take exactly 9 cycles, step k=0..8 with window w=256>>k.
REQ-022 Left mode: if the top w bits of the working row are all zero, the working row SHALL shift left by w and the index SHALL add w.
REQ-023 Right mode: if the bottom w bits are all zero, the working row SHALL shift right by w and the index SHALL add w.
REQ-024 An all-zero row SHALL yield index 511 and found=0.
REQ-025 After step 8: found=1 SHALL go to REQ; found=0 SHALL go to DONE without asserting o_mg_trig and with o_mask=0.
REQ-026 REQ SHALL drive o_mg_trig=1 and clear the timeout counter on entry.
REQ-027 REQ: i_mg_done=1 SHALL capture i_mg_mask into o_mask in that cycle and go to REL.
REQ-028 REQ: TIMEOUT cycles without i_mg_done SHALL set o_err=1 and o_mask=0, then go to REL.
REQ-029 REL SHALL drive o_mg_trig=0 and wait for i_mg_done=0 (four-phase handshake), then go to DONE.
REQ-030 REL has no timeout; i_mg_done stuck at 1 SHALL hold the block in REL.
REQ-031 o_mg_bound_index and o_mg_left_or_right SHALL be registered and stable from o_mg_trig rise until i_mg_done falls; they are 0 in IDLE.
REQ-032 DONE SHALL assert o_done for exactly one cycle, then go to IDLE.
REQ-033 o_index, o_found, o_mask and o_err SHALL stay valid from DONE until the next accepted i_start.
REQ-034 A new request SHALL clear o_err.
REQ-035 i_start asserted while o_busy=1 SHALL be ignored; no queueing.
REQ-036 Minimum latency, start to o_done: 11 cycles when found=0; 9 + mask-generator latency + 3 otherwise.

Reset
REQ-037 i_rstn low SHALL force IDLE and clear to zero all outputs, latched row, index, and counters.
REQ-038 Reset mid-operation SHALL drop o_mg_trig immediately and abandon the request with no o_done.
REQ-039 The first i_start after reset release SHALL be processed normally.

Structure
REQ-040 A shared package SHALL hold the state encoding, ROW_W, the index width (9), and the default TIMEOUT.
REQ-041 The search datapath SHALL be a single sub-module, zero_run_step, computing one window test and shift; it is instantiated once and reused across the 9 steps.
REQ-042 No combinational path SHALL exist from i_mg_done or i_mg_mask to any output.

Verification
REQ-043 Left, row bit 500 only set -> o_index=11, o_found=1, o_mg_bound_index=11 held through handshake, o_done single pulse.
REQ-044 Right, row bit 3 only set -> o_index=3; with model generator, o_mask=512'h7.
REQ-045 Left, row = 512'h1 -> o_index=511; left, bit 511 set -> o_index=0, o_mask=0.
REQ-046 Row all zero -> o_found=0, o_index=511, o_mg_trig never high, o_done 11 cycles after i_start.
REQ-047 i_mg_done held 0 -> o_err=1 after 32 REQ cycles, o_mask=0, then o_done; next start clears o_err.
REQ-048 i_rstn pulsed low during REQ -> o_mg_trig=0 asynchronously, no o_done; next request completes correctly.

Source files
------------

// File: rtl/bound_search_512bit_pkg.sv
// Shared definitions for the 512-bit first-set-bit bound search.
package bound_search_512bit_pkg;

    localparam int BS_ROW_W   = 512;
    localparam int BS_IDX_W   = 9;
    localparam int BS_TIMEOUT = 32;
    localparam int BS_STEPS   = 9;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SEARCH = 3'd1,
        S_REQ    = 3'd2,
        S_REL    = 3'd3,
        S_DONE   = 3'd4
    } state_t;

endpackage

// File: rtl/bound_search_512bit_zero_run_step.sv
// One binary-search step: test a window of 256>>step bits on the chosen side
// and, if it is all zero, shift it out and add its width to the index.
module zero_run_step
    import bound_search_512bit_pkg::*;
#(
    parameter int ROW_W = BS_ROW_W
) (
    input  logic [ROW_W-1:0]    i_row,
    input  logic [BS_IDX_W-1:0] i_idx,
    input  logic                i_left_or_right,
    input  logic [3:0]          i_step,
    output logic [ROW_W-1:0]    o_row,
    output logic [BS_IDX_W-1:0] o_idx
);

    logic [BS_IDX_W-1:0] w_win;
    logic [ROW_W-1:0]    w_ones;
    logic [ROW_W-1:0]    w_hi_mask;
    logic [ROW_W-1:0]    w_lo_mask;
    logic                w_zero;

    assign w_win     = BS_IDX_W'(256) >> i_step;
    assign w_ones    = '1;
    assign w_hi_mask = ~(w_ones >> w_win);
    assign w_lo_mask = ~(w_ones << w_win);

    assign w_zero = i_left_or_right ? ((i_row & w_lo_mask) == '0)
                                    : ((i_row & w_hi_mask) == '0);

    assign o_row = !w_zero         ? i_row :
                   i_left_or_right ? (i_row >> w_win) : (i_row << w_win);
    assign o_idx = i_idx + (w_zero ? w_win : '0);

endmodule

// File: rtl/bound_search_512bit.sv
// Finds the zero run before the first set bit of a row, then requests a mask
// from an external generator over a four-phase handshake with timeout.
module bound_search_512bit
    import bound_search_512bit_pkg::*;
#(
    parameter int ROW_W   = BS_ROW_W,
    parameter int TIMEOUT = BS_TIMEOUT
) (
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic                i_start,
    input  logic                i_left_or_right,
    input  logic [ROW_W-1:0]    i_row,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_found,
    output logic                o_err,
    output logic [BS_IDX_W-1:0] o_index,
    output logic [ROW_W-1:0]    o_mask,
    output logic                o_mg_trig,
    output logic                o_mg_left_or_right,
    output logic [BS_IDX_W-1:0] o_mg_bound_index,
    input  logic                i_mg_done,
    input  logic [ROW_W-1:0]    i_mg_mask
);

    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t              r_state;
    logic [ROW_W-1:0]    r_row;
    logic                r_lr;
    logic                r_found;
    logic                r_err;
    logic                r_busy;
    logic                r_done;
    logic                r_trig;
    logic                r_mg_lr;
    logic [3:0]          r_step;
    logic [TMO_W-1:0]    r_tmo;
    logic [BS_IDX_W-1:0] r_idx;
    logic [BS_IDX_W-1:0] r_mg_idx;
    logic [ROW_W-1:0]    r_mask;
    logic [ROW_W-1:0]    w_row_next;
    logic [BS_IDX_W-1:0] w_idx_next;

    zero_run_step #(.ROW_W(ROW_W)) u_step (
        .i_row           (r_row),
        .i_idx           (r_idx),
        .i_left_or_right (r_lr),
        .i_step          (r_step),
        .o_row           (w_row_next),
        .o_idx           (w_idx_next)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_state  <= S_IDLE;
            r_row    <= '0;
            r_lr     <= 1'b0;
            r_found  <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_trig   <= 1'b0;
            r_mg_lr  <= 1'b0;
            r_step   <= '0;
            r_tmo    <= '0;
            r_idx    <= '0;
            r_mg_idx <= '0;
            r_mask   <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_row   <= i_row;
                        r_lr    <= i_left_or_right;
                        r_found <= |i_row;
                        r_step  <= '0;
                        r_idx   <= '0;
                        r_err   <= 1'b0;
                        r_mask  <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_SEARCH;
                    end
                end
                S_SEARCH: begin
                    r_row  <= w_row_next;
                    r_idx  <= w_idx_next;
                    r_step <= r_step + 4'd1;
                    if (r_step == 4'(BS_STEPS - 1)) begin
                        if (r_found) begin
                            r_trig   <= 1'b1;
                            r_mg_idx <= w_idx_next;
                            r_mg_lr  <= r_lr;
                            r_tmo    <= '0;
                            r_state  <= S_REQ;
                        end else begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_REQ: begin
                    if (i_mg_done) begin
                        r_mask  <= i_mg_mask;
                        r_trig  <= 1'b0;
                        r_state <= S_REL;
                    end else if (r_tmo == TMO_W'(TIMEOUT - 1)) begin
                        r_err   <= 1'b1;
                        r_mask  <= '0;
                        r_trig  <= 1'b0;
                        r_state <= S_REL;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_REL: begin
                    // Forwarded side/index stay held here until the generator releases done.
                    if (!i_mg_done) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_busy   <= 1'b0;
                    r_mg_idx <= '0;
                    r_mg_lr  <= 1'b0;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy             = r_busy;
    assign o_done             = r_done;
    assign o_found            = r_found;
    assign o_err              = r_err;
    assign o_index            = r_idx;
    assign o_mask             = r_mask;
    assign o_mg_trig          = r_trig;
    assign o_mg_left_or_right = r_mg_lr;
    assign o_mg_bound_index   = r_mg_idx;

endmodule

// File: tb/tb_bound_search_512bit.sv
// Directed bench for bound_search_512bit with a reference model of the search
// result and a behavioural mask generator on the handshake port.
module tb_bound_search_512bit;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         start = 1'b0;
    logic         side = 1'b0;
    logic [511:0] row = '0;
    logic         busy, done, found, err, mg_trig, mg_lr;
    logic [8:0]   index, mg_idx;
    logic [511:0] mask;
    logic         mg_done;
    logic         mg_done_q = 1'b0;
    logic [511:0] mg_mask = '0;

    int  n_chk = 0;
    int  n_fail = 0;
    int  mg_lat = 0;
    bit  mg_mute = 1'b0;
    int  mg_cnt = 0;

    logic [8:0]   e_idx = '0;
    logic         e_found = 1'b0;
    logic         e_err = 1'b0;
    logic         e_lr = 1'b0;
    logic [511:0] e_mask = '0;
    bit           in_txn = 1'b0;
    bit           res_valid = 1'b0;
    int           trig_cycles = 0;
    int           done_cnt = 0;

    bound_search_512bit #(.ROW_W(512), .TIMEOUT(32)) dut (
        .i_clk              (clk),
        .i_rstn             (rstn),
        .i_start            (start),
        .i_left_or_right    (side),
        .i_row              (row),
        .o_busy             (busy),
        .o_done             (done),
        .o_found            (found),
        .o_err              (err),
        .o_index            (index),
        .o_mask             (mask),
        .o_mg_trig          (mg_trig),
        .o_mg_left_or_right (mg_lr),
        .o_mg_bound_index   (mg_idx),
        .i_mg_done          (mg_done),
        .i_mg_mask          (mg_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Zeros counted from the chosen side before the first one; an empty row reports 511.
    function automatic logic [8:0] ref_index(input logic [511:0] r, input logic s);
        int n = 0;
        for (int i = 0; i < 512; i++) begin
            if (r[s ? i : 511 - i]) return 9'(n);
            n++;
        end
        return 9'd511;
    endfunction

    // Generator result: the idx bits on the searched side, outside the bound.
    function automatic logic [511:0] ref_mask(input logic [8:0] idx, input logic s);
        logic [511:0] m = '0;
        for (int i = 0; i < int'(idx); i++) m[s ? i : 511 - i] = 1'b1;
        return m;
    endfunction

    always @(posedge clk) begin
        if (!mg_trig) begin
            mg_done_q <= 1'b0;
            mg_cnt    <= 0;
        end else if (!mg_mute && !mg_done_q) begin
            if (mg_cnt == mg_lat) begin
                mg_done_q <= 1'b1;
                mg_mask   <= ref_mask(mg_idx, mg_lr);
            end else begin
                mg_cnt <= mg_cnt + 1;
            end
        end
    end
    assign mg_done = mg_done_q & mg_trig;

    always @(negedge clk) begin
        if (rstn) begin
            if (mg_trig) begin
                trig_cycles++;
                chk("mg_bound_index", 512'(mg_idx), 512'(e_idx));
                chk("mg_left_or_right", 512'(mg_lr), 512'(e_lr));
            end
            if (done) begin
                done_cnt++;
                chk("done_inside_txn", 512'(done), 512'(in_txn));
                chk("busy_in_done", 512'(busy), 512'(1));
                chk("index", 512'(index), 512'(e_idx));
                chk("found", 512'(found), 512'(e_found));
                chk("err", 512'(err), 512'(e_err));
                chk("mask", mask, e_mask);
                res_valid = 1'b1;
            end else if (!busy && res_valid) begin
                chk("hold_index", 512'(index), 512'(e_idx));
                chk("hold_found", 512'(found), 512'(e_found));
                chk("hold_err", 512'(err), 512'(e_err));
                chk("hold_mask", mask, e_mask);
            end
            if (!busy) begin
                chk("idle_mg_index", 512'(mg_idx), 512'(0));
                chk("idle_mg_lr", 512'(mg_lr), 512'(0));
                chk("idle_mg_trig", 512'(mg_trig), 512'(0));
            end
        end
    end

    task automatic run_txn(input logic [511:0] row_v, input logic s, input bit poke, output int lat);
        @(posedge clk);
        #2;
        e_found     = |row_v;
        e_idx       = ref_index(row_v, s);
        e_lr        = s;
        e_err       = e_found && mg_mute;
        e_mask      = (e_found && !mg_mute) ? ref_mask(e_idx, s) : '0;
        res_valid   = 1'b0;
        in_txn      = 1'b1;
        trig_cycles = 0;
        done_cnt    = 0;
        row         = row_v;
        side        = s;
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat   = 2;
        while (!done && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (poke && lat == 4) begin
                start = 1'b1;
                row   = ~row_v;
                side  = ~s;
            end else begin
                start = 1'b0;
            end
        end
        if (!done) chk("done_wait_budget", 512'(done), 512'(1));
        @(posedge clk);
        #1;
        chk("done_single_pulse", 512'(done), 512'(0));
        chk("idle_after_done", 512'(busy), 512'(0));
        in_txn = 1'b0;
    endtask

    logic [511:0] vec_row [6];
    logic         vec_side [6];
    logic [8:0]   vec_idx [6];

    initial begin
        int lat;
        int w;
        logic [511:0] r;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", 512'(busy), 512'(0));
        chk("rst_done", 512'(done), 512'(0));
        chk("rst_found", 512'(found), 512'(0));
        chk("rst_err", 512'(err), 512'(0));
        chk("rst_index", 512'(index), 512'(0));
        chk("rst_mask", mask, 512'(0));
        chk("rst_trig", 512'(mg_trig), 512'(0));
        chk("rst_mg_index", 512'(mg_idx), 512'(0));
        res_valid = 1'b1;
        @(posedge clk);
        #2 rstn = 1'b1;
        repeat (2) @(posedge clk);

        // Left, only bit 500: 11 leading zeros.
        mg_lat = 1;
        r = '0; r[500] = 1'b1;
        run_txn(r, 1'b0, 1'b0, lat);
        chk("lit_b500_index", 512'(index), 512'(11));
        chk("lit_b500_found", 512'(found), 512'(1));
        chk("b500_req_cycles", 512'(trig_cycles), 512'(mg_lat + 2));
        chk("b500_latency", 512'(lat), 512'(9 + trig_cycles + 3));
        chk("b500_done_count", 512'(done_cnt), 512'(1));

        // Right, only bit 3: mask of the three low bits.
        mg_lat = 0;
        r = '0; r[3] = 1'b1;
        run_txn(r, 1'b1, 1'b0, lat);
        chk("lit_b3_index", 512'(index), 512'(3));
        chk("lit_b3_mask", mask, 512'h7);

        r = 512'h1;
        run_txn(r, 1'b0, 1'b0, lat);
        chk("lit_lsb_left_index", 512'(index), 512'(511));

        r = '0; r[511] = 1'b1;
        run_txn(r, 1'b0, 1'b0, lat);
        chk("lit_msb_left_index", 512'(index), 512'(0));
        chk("lit_msb_left_mask", mask, 512'(0));

        // Empty row in both directions: no generator request, fixed latency.
        for (int s = 0; s < 2; s++) begin
            run_txn('0, 1'(s), 1'b0, lat);
            chk("lit_zero_found", 512'(found), 512'(0));
            chk("lit_zero_index", 512'(index), 512'(511));
            chk("zero_trig_cycles", 512'(trig_cycles), 512'(0));
            chk("lit_zero_latency", 512'(lat), 512'(11));
        end

        // Start pulsed mid-search with a different row must not disturb the result.
        mg_lat = 3;
        r = '0; r[200] = 1'b1; r[300] = 1'b1;
        run_txn(r, 1'b1, 1'b1, lat);
        chk("lit_poke_index", 512'(index), 512'(200));
        chk("poke_done_count", 512'(done_cnt), 512'(1));

        vec_row[0] = '0; vec_row[0][256] = 1'b1; vec_row[0][10] = 1'b1; vec_side[0] = 1'b0; vec_idx[0] = 9'd255;
        vec_row[1] = 512'h100;                                          vec_side[1] = 1'b1; vec_idx[1] = 9'd8;
        vec_row[2] = '1;                                                 vec_side[2] = 1'b0; vec_idx[2] = 9'd0;
        vec_row[3] = '1;                                                 vec_side[3] = 1'b1; vec_idx[3] = 9'd0;
        vec_row[4] = '0; vec_row[4][255] = 1'b1;                         vec_side[4] = 1'b1; vec_idx[4] = 9'd255;
        vec_row[5] = '0; vec_row[5][256] = 1'b1; vec_row[5][1] = 1'b1;   vec_side[5] = 1'b0; vec_idx[5] = 9'd255;
        mg_lat = 2;
        for (int i = 0; i < 6; i++) begin
            run_txn(vec_row[i], vec_side[i], 1'b0, lat);
            chk("lit_table_index", 512'(index), 512'(vec_idx[i]));
        end

        // Silent generator: timeout after 32 request cycles.
        mg_mute = 1'b1;
        r = '0; r[100] = 1'b1;
        run_txn(r, 1'b0, 1'b0, lat);
        chk("lit_tmo_err", 512'(err), 512'(1));
        chk("lit_tmo_mask", mask, 512'(0));
        chk("tmo_req_cycles", 512'(trig_cycles), 512'(32));
        chk("lit_tmo_latency", 512'(lat), 512'(44));
        mg_mute = 1'b0;
        mg_lat  = 0;
        run_txn(r, 1'b0, 1'b0, lat);
        chk("lit_err_cleared", 512'(err), 512'(0));

        // Reset while the request is outstanding.
        mg_lat = 20;
        @(posedge clk);
        #2;
        r = '0; r[50] = 1'b1;
        e_idx = ref_index(r, 1'b0);
        e_lr = 1'b0;
        res_valid = 1'b0;
        in_txn = 1'b1;
        row = r;
        side = 1'b0;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        w = 0;
        while (!mg_trig && w < 100) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("rst_trig_seen", 512'(mg_trig), 512'(1));
        repeat (3) @(posedge clk);
        #2;
        rstn = 1'b0;
        in_txn = 1'b0;
        e_idx = '0; e_found = 1'b0; e_err = 1'b0; e_mask = '0; e_lr = 1'b0;
        res_valid = 1'b1;
        #1;
        chk("rst_trig_async_drop", 512'(mg_trig), 512'(0));
        chk("rst_busy_async_drop", 512'(busy), 512'(0));
        chk("rst_index_cleared", 512'(index), 512'(0));
        @(posedge clk);
        #2 rstn = 1'b1;
        done_cnt = 0;
        repeat (15) @(posedge clk);
        chk("no_done_after_reset", 512'(done_cnt), 512'(0));

        mg_lat = 1;
        r = '0; r[500] = 1'b1;
        run_txn(r, 1'b0, 1'b0, lat);
        chk("post_reset_index", 512'(index), 512'(11));
        chk("post_reset_found", 512'(found), 512'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running want finished");
        $fatal(1);
    end

endmodule
